axil_csr_master: RTL
====================

Name: axil_csr_master

Overview:
- Synthesizable AXI-Lite initiator: turns a simple request/response command port into single-beat AXI-Lite CSR writes and reads.
- Drives the axil_* slave port of accelerator wrappers (e.g. the average accelerator CSR block) from on-chip control logic instead of a bench task.
- One outstanding transaction at a time; a progress watchdog flags a hung slave.

Parameters:
- ADDR_WIDTH, 12, AXI-Lite address width.
- DATA_WIDTH, 32, AXI-Lite data width (32 only).
- TIMEOUT_CYCLES, 1024, wait cycles without a handshake before hang is flagged; 0 disables the watchdog.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when both req_valid and req_ready are high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  4  write byte strobes.
- resp_valid  out  1  completion valid.
- resp_ready  in  1  completion accepted.
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- resp_resp  out  2  BRESP or RRESP of the transaction.
- timeout  out  1  sticky hang flag.
- axil_aw_valid/axil_aw_ready/axil_aw_addr  out/in/out  1/1/ADDR_WIDTH  write address channel.
- axil_w_valid/axil_w_ready/axil_w_data/axil_w_strb  out/in/out/out  1/1/DATA_WIDTH/4  write data channel.
- axil_b_valid/axil_b_ready/axil_b_resp  in/out/in  1/1/2  write response channel.
- axil_ar_valid/axil_ar_ready/axil_ar_addr  out/in/out  1/1/ADDR_WIDTH  read address channel.
- axil_r_valid/axil_r_ready/axil_r_data/axil_r_resp  in/out/in/in  1/1/DATA_WIDTH/2  read data channel.

Behaviour:
- Reset (asynchronous, active-high):
  - Every valid, ready and flag output is 0; all data/address outputs are 0.
  - State = IDLE.
  - req_ready rises in the first cycle after reset deasserts.
- All outputs are registered. req_ready = 1 only in IDLE.
- States:
  - IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP, HUNG.
- IDLE:
  - On req accept, latch addr/wdata/wstrb.
  - Write: go to WR_ADDR_DATA and assert axil_aw_valid and axil_w_valid together in the next cycle.
  - Read: go to RD_ADDR and assert axil_ar_valid in the next cycle.
- WR_ADDR_DATA:
  - AW and W complete independently, in either order or in the same cycle.
  - Each valid drops the cycle after its own handshake.
  - When both are done, go to WR_RESP with axil_b_ready = 1.
  - Valid never drops before its handshake; address and data stay stable while valid.
- WR_RESP:
  - On the B handshake, capture b_resp, drop b_ready, and go to RESP.
  - resp_rdata = 0.
- RD_ADDR:
  - On the AR handshake, drop ar_valid and go to RD_DATA with axil_r_ready = 1.
- RD_DATA:
  - On the R handshake, capture r_data/r_resp, drop r_ready, and go to RESP.
- RESP:
  - resp_valid = 1; data is held until resp_ready.
  - On the response handshake, go to IDLE; req_ready = 1 in the next cycle.
- Latency with an always-ready slave:
  - Accept at cycle 0, channel valid at 1, B/R handshake at 2, resp_valid at 3, req_ready at 4 (given resp_ready at 3).
- b_resp/r_resp pass through unmodified. SLVERR/DECERR are not errors of this block.
- Unsolicited b_valid/r_valid outside WR_RESP/RD_DATA is ignored: the matching ready is 0, so there is no handshake.
- Watchdog:
  - Counter clears on state entry and on every AXI handshake.
  - Counter increments each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
  - It does not count in IDLE or RESP.
  - On reaching TIMEOUT_CYCLES: timeout = 1 and state = HUNG.
- HUNG:
  - Outstanding valids are held, so there is no protocol violation.
  - req_ready = 0 and resp_valid = 0.
  - Exit only via reset.
- Reset mid-transaction: all valids drop immediately. The attached slave shares the same reset.

Test Plan:
- Write 0x20, data 0x8, strb 0xF; slave always ready, bresp 0 -> aw/w valid at cycle 1 with addr 0x20 and data 0x8; resp_valid at cycle 3 with resp_resp 0 and resp_rdata 0.
- Read 0x20 after the above -> ar_valid at cycle 1; resp_valid at cycle 3 with resp_rdata 0x8 and resp_resp 0.
- Write 0x10; slave holds awready low 5 cycles while wready is immediate -> w_valid drops at cycle 2; aw_valid drops the cycle after awready; b_ready is asserted only once both are done.
- Read; slave returns rresp 2'b10 with rdata 0xDEAD -> resp_resp 2'b10 and resp_rdata 0xDEAD; resp_ready held low 3 cycles -> response stable and req_ready 0 until the response handshake.
- TIMEOUT_CYCLES = 16; slave never asserts arready -> timeout = 1 after 16 RD_ADDR cycles; ar_valid stays 1; req_ready stays 0; reset clears timeout and all valids.
- 24 back-to-back writes to 0x20..0x7C (data = addr/4), then 24 reads -> every readback matches; each read issues no earlier than 1 cycle after the previous response handshake.

Source files
------------

// File: rtl/axil_csr_master.sv
// axil_csr_master: single-outstanding AXI-Lite initiator for CSR access.
// A req/resp command port is turned into one AXI-Lite write (AW+W, then B)
// or read (AR, then R). All outputs are registered. A watchdog moves the
// FSM to a terminal HUNG state when a slave stops making progress.
module axil_csr_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    // command port
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wstrb,
    // completion port
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [1:0]            resp_resp,
    output logic                  timeout,
    // AXI-Lite write address
    output logic                  axil_aw_valid,
    input  logic                  axil_aw_ready,
    output logic [ADDR_WIDTH-1:0] axil_aw_addr,
    // AXI-Lite write data
    output logic                  axil_w_valid,
    input  logic                  axil_w_ready,
    output logic [DATA_WIDTH-1:0] axil_w_data,
    output logic [3:0]            axil_w_strb,
    // AXI-Lite write response
    input  logic                  axil_b_valid,
    output logic                  axil_b_ready,
    input  logic [1:0]            axil_b_resp,
    // AXI-Lite read address
    output logic                  axil_ar_valid,
    input  logic                  axil_ar_ready,
    output logic [ADDR_WIDTH-1:0] axil_ar_addr,
    // AXI-Lite read data
    input  logic                  axil_r_valid,
    output logic                  axil_r_ready,
    input  logic [DATA_WIDTH-1:0] axil_r_data,
    input  logic [1:0]            axil_r_resp
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_AD     = 3'd1;
    localparam logic [2:0] S_WR_RESP   = 3'd2;
    localparam logic [2:0] S_RD_ADDR   = 3'd3;
    localparam logic [2:0] S_RD_DATA   = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;
    localparam logic [2:0] S_HUNG      = 3'd6;

    localparam int              WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES);
    localparam bit              WD_EN  = (TIMEOUT_CYCLES != 0);

    logic [2:0]            r_state;
    logic                  r_req_ready;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic [1:0]            r_resp_resp;
    logic                  r_timeout;
    logic                  r_aw_valid;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_valid;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [3:0]            r_w_strb;
    logic                  r_b_ready;
    logic                  r_ar_valid;
    logic [ADDR_WIDTH-1:0] r_ar_addr;
    logic                  r_r_ready;
    logic [WD_W-1:0]       r_wdog;

    logic            w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_any_hs;
    logic            w_waiting;
    logic [WD_W-1:0] w_wd_inc;
    logic            w_wd_hit;

    assign w_aw_hs  = r_aw_valid & axil_aw_ready;
    assign w_w_hs   = r_w_valid  & axil_w_ready;
    assign w_b_hs   = r_b_ready  & axil_b_valid;
    assign w_ar_hs  = r_ar_valid & axil_ar_ready;
    assign w_r_hs   = r_r_ready  & axil_r_valid;
    assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

    // Only the states that wait on the slave are watched; IDLE/RESP wait on us.
    assign w_waiting = (r_state == S_WR_AD) || (r_state == S_WR_RESP) ||
                       (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
    assign w_wd_inc  = r_wdog + 1'b1;
    assign w_wd_hit  = WD_EN && w_waiting && !w_any_hs && (w_wd_inc == WD_LIM);

    // Watchdog: every state entry out of a waiting state coincides with a
    // handshake, so clearing on handshakes and outside waiting states is
    // equivalent to clearing on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_wdog <= '0;
        else if (!w_waiting || w_any_hs)
            r_wdog <= '0;
        else
            r_wdog <= w_wd_inc;
    end

    // Transaction FSM and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_resp  <= 2'b00;
            r_timeout    <= 1'b0;
            r_aw_valid   <= 1'b0;
            r_aw_addr    <= '0;
            r_w_valid    <= 1'b0;
            r_w_data     <= '0;
            r_w_strb     <= 4'h0;
            r_b_ready    <= 1'b0;
            r_ar_valid   <= 1'b0;
            r_ar_addr    <= '0;
            r_r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (req_write) begin
                            r_aw_addr  <= req_addr;
                            r_w_data   <= req_wdata;
                            r_w_strb   <= req_wstrb;
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_state    <= S_WR_AD;
                        end else begin
                            r_ar_addr  <= req_addr;
                            r_ar_valid <= 1'b1;
                            r_state    <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_AD: begin
                    // AW and W retire independently; a channel counts as done
                    // once its valid has dropped or it handshakes right now.
                    if (w_aw_hs) r_aw_valid <= 1'b0;
                    if (w_w_hs)  r_w_valid  <= 1'b0;
                    if ((!r_aw_valid || w_aw_hs) && (!r_w_valid || w_w_hs)) begin
                        r_b_ready <= 1'b1;
                        r_state   <= S_WR_RESP;
                    end else if (w_wd_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_HUNG;
                    end
                end
                S_WR_RESP: begin
                    if (w_b_hs) begin
                        r_b_ready    <= 1'b0;
                        r_resp_resp  <= axil_b_resp;
                        r_resp_rdata <= '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_wd_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_HUNG;
                    end
                end
                S_RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= S_RD_DATA;
                    end else if (w_wd_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_HUNG;
                    end
                end
                S_RD_DATA: begin
                    if (w_r_hs) begin
                        r_r_ready    <= 1'b0;
                        r_resp_rdata <= axil_r_data;
                        r_resp_resp  <= axil_r_resp;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (w_wd_hit) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_HUNG;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                S_HUNG: begin
                    // Outstanding valids/readies stay up; a late handshake
                    // retires that channel so it is never presented twice.
                    if (w_aw_hs) r_aw_valid <= 1'b0;
                    if (w_w_hs)  r_w_valid  <= 1'b0;
                    if (w_b_hs)  r_b_ready  <= 1'b0;
                    if (w_ar_hs) r_ar_valid <= 1'b0;
                    if (w_r_hs)  r_r_ready  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign resp_resp     = r_resp_resp;
    assign timeout       = r_timeout;
    assign axil_aw_valid = r_aw_valid;
    assign axil_aw_addr  = r_aw_addr;
    assign axil_w_valid  = r_w_valid;
    assign axil_w_data   = r_w_data;
    assign axil_w_strb   = r_w_strb;
    assign axil_b_ready  = r_b_ready;
    assign axil_ar_valid = r_ar_valid;
    assign axil_ar_addr  = r_ar_addr;
    assign axil_r_ready  = r_r_ready;

endmodule
